// File: rtl/estimate_seq.sv
// Job sequencer for the estimate array: ini, K acc beats per window, pool, then norm/activ and a result.
// Optional feature: define ESTIMATE_SEQ_STALL_CNT_EN to add the stall_cnt output.
module estimate_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cfg_k,
  input  logic [1:0]  cfg_p,
  input  logic [15:0] cfg_wbase,
  input  logic [15:0] cfg_nbase,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic [2:0]  com,
  output logic [15:0] addr,
  output logic [63:0] data,
  input  logic [63:0] activ,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic [2:0]  state_dbg
`ifdef ESTIMATE_SEQ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  // Handshakes: a beat moves when valid and ready are both high at a rising edge;
  // valid never depends on ready, and a held valid keeps its payload stable.
  localparam logic [2:0] CMD_INI   = 3'd0;
  localparam logic [2:0] CMD_ACC   = 3'd1;
  localparam logic [2:0] CMD_POOL  = 3'd2;
  localparam logic [2:0] CMD_NORM  = 3'd3;
  localparam logic [2:0] CMD_ACTIV = 3'd4;
  localparam logic [2:0] CMD_NOP   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC  = 3'd1,
    S_POOL = 3'd2,
    S_NORM = 3'd3,
    S_ACTV = 3'd4,
    S_WAIT = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  k_cnt;
  logic [7:0]  k_last;
  logic [1:0]  p_cnt;
  logic [1:0]  p_last;
  logic [15:0] wbase_r;
  logic [15:0] nbase_r;
  logic [1:0]  wait_cnt;

  assign in_ready  = (state == S_ACC);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      com       <= CMD_NOP;
      addr      <= 16'h0;
      data      <= 64'h0;
      out_valid <= 1'b0;
      out_data  <= 64'h0;
      k_cnt     <= 8'h0;
      k_last    <= 8'h0;
      p_cnt     <= 2'h0;
      p_last    <= 2'h0;
      wbase_r   <= 16'h0;
      nbase_r   <= 16'h0;
      wait_cnt  <= 2'h0;
`ifdef ESTIMATE_SEQ_STALL_CNT_EN
      stall_cnt <= 32'h0;
`endif
    end else begin
      com <= CMD_NOP;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // out_valid still high means the previous result is unclaimed
          if (start && !out_valid) begin
            com     <= CMD_INI;
            data    <= 64'h0;
            addr    <= cfg_wbase;
            k_cnt   <= 8'h0;
            p_cnt   <= 2'h0;
            k_last  <= cfg_k - 8'd1;
            p_last  <= cfg_p - 2'd1;
            wbase_r <= cfg_wbase;
            nbase_r <= cfg_nbase;
            state   <= S_ACC;
`ifdef ESTIMATE_SEQ_STALL_CNT_EN
            stall_cnt <= 32'h0;
`endif
          end
        end
        S_ACC: begin
          if (in_valid) begin
            com  <= CMD_ACC;
            data <= in_data;
            addr <= wbase_r + {8'h00, k_cnt};
            if (k_cnt == k_last) begin
              k_cnt <= 8'h0;
              state <= S_POOL;
            end else begin
              k_cnt <= k_cnt + 8'd1;
            end
          end
`ifdef ESTIMATE_SEQ_STALL_CNT_EN
          else if (stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
          end
`endif
        end
        S_POOL: begin
          com  <= CMD_POOL;
          data <= 64'h0;
          if (p_cnt != p_last) begin
            p_cnt <= p_cnt + 2'd1;
            state <= S_ACC;
          end else begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          com   <= CMD_NORM;
          addr  <= nbase_r;
          state <= S_ACTV;
        end
        S_ACTV: begin
          com      <= CMD_ACTIV;
          addr     <= nbase_r;
          wait_cnt <= 2'h0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // array returns activations three cycles after the activ command
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == 2'd3) begin
            out_data  <= activ;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_estimate_seq.sv
// Bench for estimate_seq: table of job configurations plus hand sequences for
// result back-pressure and mid-job reset.
module tb_estimate_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_k = 8'h0;
  logic [1:0]  cfg_p = 2'h0;
  logic [15:0] cfg_wbase = 16'h0;
  logic [15:0] cfg_nbase = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'h0;
  logic [2:0]  com;
  logic [15:0] addr;
  logic [63:0] data;
  logic [63:0] activ = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;
  logic [2:0]  state_dbg;
`ifdef ESTIMATE_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  estimate_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_k     (cfg_k),
    .cfg_p     (cfg_p),
    .cfg_wbase (cfg_wbase),
    .cfg_nbase (cfg_nbase),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .com       (com),
    .addr      (addr),
    .data      (data),
    .activ     (activ),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .state_dbg (state_dbg)
`ifdef ESTIMATE_SEQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [7:0]  k;
    logic [1:0]  p;
    logic [15:0] wbase;
    logic [15:0] nbase;
    int          stall_at;
    int          stall_len;
    int          lat;
    int          n_acc;
    int          n_pool;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    activ = {$urandom, $urandom};
  endtask

  // Runs one job from start to out_valid; the result is left pending.
  task automatic run_job(input vec_t v);
    int base, rel, kk, k_eff, acc_seen, pool_seen, nop_seen, c4, t_valid;
    logic seen_norm, stalled;
    logic [63:0] exp_out, prev_data;
    logic [15:0] prev_addr, ea;
    exp_q.delete();
    k_eff = (v.k == 8'd0) ? 256 : int'(v.k);
    kk = 0; acc_seen = 0; pool_seen = 0; nop_seen = 0; c4 = -1; t_valid = -1;
    seen_norm = 1'b0; exp_out = 64'h0;
    prev_addr = addr; prev_data = data;
    base = cyc;
    start = 1'b1; cfg_k = v.k; cfg_p = v.p; cfg_wbase = v.wbase; cfg_nbase = v.nbase;
    in_valid = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < v.lat + 40 && t_valid < 0; i++) begin
      rel = cyc - base;
      case (com)
        3'd0: begin
          check("ini_cycle", 64'(rel), 64'd1);
          check("ini_addr", 64'(addr), 64'(v.wbase));
          check("ini_data", data, 64'h0);
        end
        3'd1: begin
          ea = v.wbase + 16'(kk);
          check("acc_addr", 64'(addr), 64'(ea));
          if (exp_q.size() == 0) check("acc_unexpected", 64'(com), 64'd7);
          else check("acc_data", data, exp_q.pop_front());
          kk++;
          acc_seen++;
        end
        3'd2: begin
          check("pool_data", data, 64'h0);
          check("pool_window_len", 64'(kk), 64'(k_eff));
          kk = 0;
          pool_seen++;
        end
        3'd3: begin
          check("norm_addr", 64'(addr), 64'(v.nbase));
          check("norm_cycle", 64'(rel), 64'(v.lat - 5));
          seen_norm = 1'b1;
        end
        3'd4: begin
          check("activ_addr", 64'(addr), 64'(v.nbase));
          c4 = rel;
        end
        3'd7: begin
          check("nop_addr_hold", 64'(addr), 64'(prev_addr));
          check("nop_data_hold", data, prev_data);
          if (!seen_norm) nop_seen++;
        end
        default: check("com_legal", 64'(com), 64'd7);
      endcase
      prev_addr = addr;
      prev_data = data;
      if (c4 >= 0 && rel == c4 + 3) exp_out = activ;
      if (out_valid) begin
        t_valid = rel;
      end else begin
        stalled = (rel >= v.stall_at) && (rel < v.stall_at + v.stall_len);
        in_valid = !stalled;
        in_data = {$urandom, $urandom};
        if (in_valid && in_ready) exp_q.push_back(in_data);
        step();
      end
    end
    in_valid = 1'b0;
    check("out_valid_latency", 64'(t_valid), 64'(v.lat));
    check("out_data", out_data, exp_out);
    check("acc_beats", 64'(acc_seen), 64'(v.n_acc));
    check("pool_count", 64'(pool_seen), 64'(v.n_pool));
    check("stall_nops", 64'(nop_seen), 64'(v.stall_len));
    check("busy_at_result", 64'(busy), 64'd0);
    check("leftover_beats", 64'(exp_q.size()), 64'd0);
`ifdef ESTIMATE_SEQ_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(v.stall_len));
`endif
  endtask

  task automatic ack_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_cleared", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    vecs[0] = '{k: 8'd2, p: 2'd1, wbase: 16'h0010, nbase: 16'h0100, stall_at: 0, stall_len: 0, lat: 10,   n_acc: 2,    n_pool: 1};
    vecs[1] = '{k: 8'd3, p: 2'd2, wbase: 16'h0200, nbase: 16'h0300, stall_at: 2, stall_len: 2, lat: 17,   n_acc: 6,    n_pool: 2};
    vecs[2] = '{k: 8'd0, p: 2'd0, wbase: 16'hFFF0, nbase: 16'h0001, stall_at: 0, stall_len: 0, lat: 1035, n_acc: 1024, n_pool: 4};
    vecs[3] = '{k: 8'd1, p: 2'd3, wbase: 16'h1234, nbase: 16'hABCD, stall_at: 1, stall_len: 3, lat: 16,   n_acc: 3,    n_pool: 3};
    vecs[4] = '{k: 8'd5, p: 2'd1, wbase: 16'h7FFE, nbase: 16'h8000, stall_at: 0, stall_len: 0, lat: 13,   n_acc: 5,    n_pool: 1};

    // clock/reset
    step();
    step();
    check("rst_com", 64'(com), 64'd7);
    check("rst_addr", 64'(addr), 64'h0);
    check("rst_data", data, 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i]);
      ack_result();
      step();
    end

    // result held under back-pressure while start pulses are ignored
    run_job(vecs[0]);
    held = out_data;
    for (int i = 0; i < 20; i++) begin
      start = (i % 5 == 0);
      cfg_k = 8'd1; cfg_p = 2'd1;
      step();
      start = 1'b0;
      check("bp_busy", 64'(busy), 64'd0);
      check("bp_com", 64'(com), 64'd7);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", out_data, held);
    end
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    check("start_on_xfer_ignored", 64'(busy), 64'd0);
    check("xfer_out_valid", 64'(out_valid), 64'd0);
    check("xfer_com", 64'(com), 64'd7);
    run_job(vecs[4]);
    ack_result();
    step();

    // asynchronous reset in the middle of an accumulate window
    start = 1'b1; cfg_k = 8'd4; cfg_p = 2'd1; cfg_wbase = 16'h0040; cfg_nbase = 16'h0050;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h1111_2222_3333_4444;
    step();
    step();
    check("pre_rst_com", 64'(com), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_com", 64'(com), 64'd7);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_addr", 64'(addr), 64'h0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_job(vecs[1]);
    ack_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/estimate_seq.md
ESTIMATE_SEQ -- requirements
Module: estimate_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  one-cycle job request; accepted only in IDLE with out_valid=0, otherwise ignored.
REQ-004 cfg_k  in  8  acc beats per pool window; 0 means 256; sampled at accepted start.
REQ-005 cfg_p  in  2  pool windows per job; 0 means 4; sampled at accepted start.
REQ-006 cfg_wbase  in  16  param RAM address of weight beat 0; sampled at start.
REQ-007 cfg_nbase  in  16  param RAM address of norm/threshold word; sampled at start.
REQ-008 in_valid / in_ready / in_data  in / out / in  1/1/64  input activation stream; beat transfers when in_valid=1 and in_ready=1.
REQ-009 com  out  3  registered command to estimate array: 0 ini, 1 acc, 2 pool, 3 norm, 4 activ, 7 nop.
REQ-010 addr  out  16  registered param RAM address, issued in the same cycle as com.
REQ-011 data  out  64  registered data word, issued in the same cycle as com.
REQ-012 activ  in  64  32 packed 2-bit activations returned by the estimate array.
REQ-013 out_valid / out_ready / out_data  out / in / out  1/1/64  result handshake; transfer when both high.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, ACC, POOL, NORM, ACTV, WAIT; each state's command is registered onto com/addr/data at the edge leaving that cycle.
REQ-016 IDLE + accepted start: issue com=0, data=64'h0, addr=cfg_wbase; clear k and p counters; go ACC.
REQ-017 ACC: in_ready=1 (in_ready=0 in all other states); per transfer issue com=1, data=in_data, addr=cfg_wbase+k (mod 2^16), k++.
REQ-018 ACC without a transfer: issue com=7, addr and data held; no counter changes.
REQ-019 ACC after transfer with k=K-1: go POOL, k cleared.
REQ-020 POOL: issue com=2, data=64'h0; if p<P-1 then p++ and go ACC, else go NORM.
REQ-021 NORM: issue com=3, addr=cfg_nbase; go ACTV.
REQ-022 ACTV: issue com=4, addr held at cfg_nbase; go WAIT.
REQ-023 WAIT: activ is sampled into out_data in the third cycle after the com=4 cycle; out_valid rises in the next cycle; go IDLE.
REQ-024 No-stall latency: start accepted in cycle 0 gives ini in cycle 1, norm in cycle 2+P*(K+1), and out_valid in cycle 7+P*(K+1).
REQ-025 out_valid stays high and out_data stays stable until out_ready=1; out_valid clears in the cycle after the transfer.
REQ-026 Start in the same cycle as an out_valid transfer is ignored; start is accepted from the following cycle.
REQ-027 In IDLE and WAIT, com=7 and addr/data hold their last values.

Reset
REQ-028 On rst_n=0, immediately: state=IDLE, com=3'd7, addr=0, data=0, out_valid=0, out_data=0, counters=0.
REQ-029 Reset during a job discards all partial work; the next job starts with ini, so no array reset is required.

Configuration
REQ-030 With ESTIMATE_SEQ_STALL_CNT_EN defined: 32-bit output stall_cnt increments in each ACC cycle with in_valid=0, saturates at 32'hFFFFFFFF, and clears at reset and at accepted start.
REQ-031 Without ESTIMATE_SEQ_STALL_CNT_EN: the stall_cnt port and counter are absent; all other behaviour is identical.

Verification
REQ-032 K=2, P=1, wbase=16'h0010, nbase=16'h0100, in_valid held high, start in cycle 0: com sequence 0,1,1,2,3,4 in cycles 1-6; addr 0010,0010,0011,–,0100,0100; out_valid in cycle 10, out_data = activ sampled in cycle 9.
REQ-033 K=3, P=2, in_valid low for 2 cycles mid-window: two com=7 cycles inserted; six acc beats; pool issued twice; out_valid delayed by exactly 2 cycles; with the macro on, stall_cnt=2.
REQ-034 cfg_k=0, cfg_p=0, wbase=16'hFFF0: 1024 acc beats; addr wraps FFFF to 0000; four pools.
REQ-035 out_ready held low for 20 cycles after a result, with start pulsed during that time: start is ignored, out_data stays stable, and a new start is accepted only after the transfer.
REQ-036 rst_n asserted during ACC: com goes to 7, busy=0, and out_valid=0 immediately; a following job produces correct results.
